mm_load_sched: RTL

//  Top-level load/compute sequencer for the matrix-multiply engine. Latches a job

---
 rtl/mm_load_sched_if.sv | 30 +++
 rtl/mm_load_sched.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mm_load_sched_if.sv
// Element-stream handshake plus A/B write strobes and
// the static config seen by the A/B address generators.
interface mm_load_sched_if #(
    parameter int MATRIXSIZE_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    valid_A;
    logic                    valid_B;
    logic [MATRIXSIZE_W-1:0] cfg_M2;
    logic [MATRIXSIZE_W-1:0] cfg_M3dN2;

    modport master (
        output in_valid,
        input  in_ready,
        input  valid_A,
        input  valid_B,
        input  cfg_M2,
        input  cfg_M3dN2
    );

    modport slave (
        input  in_valid,
        output in_ready,
        output valid_A,
        output valid_B,
        output cfg_M2,
        output cfg_M3dN2
    );
endinterface

// File: rtl/mm_load_sched.sv
// Matrix-multiply load/compute sequencer: steers one input
// stream to the A then B writers, then runs the compute engine.
module mm_load_sched #(
    parameter int MATRIXSIZE_W = 16,
    parameter int N2           = 4,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M1,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] M3,
    mm_load_sched_if.slave          bus,
    output logic                    compute_start,
    input  logic                    compute_done,
    output logic                    busy,
    output logic                    done,
    output logic                    err_cfg
);
    localparam int LOG2N2 = $clog2(N2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_a_q, len_a_d;
    logic [CNT_W-1:0]        len_b_q, len_b_d;
    logic [MATRIXSIZE_W-1:0] cfg_m2_q, cfg_m2_d;
    logic [MATRIXSIZE_W-1:0] cfg_m3dn2_q, cfg_m3dn2_d;
    logic                    cstart_q, cstart_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    cfg_ok;
    logic                    beat;

    assign cfg_ok = (M1 != '0) && (M2 != '0) && (M3 != '0)
                 && (M3[LOG2N2-1:0] == '0);

    assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat          = bus.in_valid && bus.in_ready;
    assign bus.valid_A   = beat && (state_q == LOAD_A);
    assign bus.valid_B   = beat && (state_q == LOAD_B);
    assign bus.cfg_M2    = cfg_m2_q;
    assign bus.cfg_M3dN2 = cfg_m3dn2_q;
    assign compute_start = cstart_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err_cfg       = err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_a_d     = len_a_q;
        len_b_d     = len_b_q;
        cfg_m2_d    = cfg_m2_q;
        cfg_m3dn2_d = cfg_m3dn2_q;
        cstart_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        cfg_m2_d    = M2;
                        cfg_m3dn2_d = M3 >> LOG2N2;
                        len_a_d     = CNT_W'(M1) * CNT_W'(M2);
                        len_b_d     = CNT_W'(M2) * CNT_W'(M3);
                        cnt_d       = '0;
                        state_d     = LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_A: begin
                if (beat) begin
                    if (cnt_q == len_a_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    if (cnt_q == len_b_q - CNT_W'(1)) begin
                        cnt_d    = '0;
                        cstart_d = 1'b1;
                        state_d  = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                // the start cycle never sees a done from a stale run
                if (compute_done && !cstart_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_a_q     <= '0;
            len_b_q     <= '0;
            cfg_m2_q    <= '0;
            cfg_m3dn2_q <= '0;
            cstart_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_a_q     <= len_a_d;
            len_b_q     <= len_b_d;
            cfg_m2_q    <= cfg_m2_d;
            cfg_m3dn2_q <= cfg_m3dn2_d;
            cstart_q    <= cstart_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule
